rpsc_ca_sequencer: RTL and testbench

Start-up and protection sequencer for the RPSC cathode-anode (CA) supply. It drives fan and CA commands through fan spin-up, supply permit, settling and hold-off delay, then monitors interlock and analog fault inputs. On a fault it trips the supply, latches a fault code and retries a bounded number of times before locking out. It replaces free-running delay chains with one supervised, timeout-checked FSM between the status inputs and the card output drivers.

---
 rtl/rpsc_pkg.sv | 66 ++++++
 rtl/rpsc_ca_sequencer_if.sv | 45 ++++
 rtl/rpsc_cycle_timer.sv | 33 +++
 rtl/rpsc_ca_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_rpsc_ca_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpsc_pkg.sv
// rpsc_pkg
// Shared types and constants for the RPSC cathode-anode supply sequencer.
//   state_t       : sequencer FSM states (4-bit, also exported as a diagnostic port)
//   fault_t       : latched fault codes, 0 = no fault
//   SB_*          : bit positions inside the 7-bit status bus
//   max_int       : elaboration-time helper for sizing the shared timer
//   status_fault  : maps a status word to the lowest-numbered fault code
package rpsc_pkg;

  localparam int STATUS_W = 7;

  // Status bus bit positions; a 1 on any of them is a fault.
  localparam int SB_CARD_POS    = 0;
  localparam int SB_AIR_GRID    = 1;
  localparam int SB_WATER_ANODE = 2;
  localparam int SB_WATER_GRID  = 3;
  localparam int SB_DC_PS       = 4;
  localparam int SB_U_CA_LOW    = 5;
  localparam int SB_I_CA_HIGH   = 6;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FAN_START = 4'd1,
    CA_PERM   = 4'd2,
    CA_SETTLE = 4'd3,
    CA_DELAY  = 4'd4,
    RUN       = 4'd5,
    SHUTDOWN  = 4'd6,
    TRIP      = 4'd7,
    LOCKOUT   = 4'd8
  } state_t;

  // Codes 1..7 are status bit index + 1, so their order follows the bus.
  typedef enum logic [3:0] {
    FLT_NONE         = 4'd0,
    FLT_CARD_POS     = 4'd1,
    FLT_AIR_GRID     = 4'd2,
    FLT_WATER_ANODE  = 4'd3,
    FLT_WATER_GRID   = 4'd4,
    FLT_DC_PS        = 4'd5,
    FLT_ST_U_CA_LOW  = 4'd6,
    FLT_ST_I_CA_HIGH = 4'd7,
    FLT_G1_NOT_OK    = 4'd8,
    FLT_FAN_TMO      = 4'd9,
    FLT_PS_TMO       = 4'd10,
    FLT_PS_LOST      = 4'd11,
    FLT_I_CA_HIGH    = 4'd12,
    FLT_U_CA_LOW     = 4'd13
  } fault_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Scanning from the top bit down lets the lowest set bit overwrite last,
  // which gives the "lowest code wins" priority.
  function automatic fault_t status_fault(input logic [STATUS_W-1:0] st);
    fault_t code;
    code = FLT_NONE;
    for (int i = STATUS_W - 1; i >= 0; i--) begin
      if (st[i]) code = fault_t'(4'(i + 1));
    end
    return code;
  endfunction

endpackage

// File: rtl/rpsc_ca_sequencer_if.sv
// rpsc_ca_sequencer_if
// Bundles the sequencer's status inputs and command/diagnostic outputs.
//   master : controller / card side (drives requests and feedback, reads commands)
//   slave  : the sequencer itself
// Inputs : start_req, stop_req, ack_clr, status[6:0], g1_not_ok, fan_act,
//          ca_ps_act, i_ca_high, u_ca_low
// Outputs: fan_on_cmd, ca_on_perm, ca_delay_done, ca_ok, alarm,
//          fault_code[3:0], retry_cnt[1:0], state[3:0]
interface rpsc_ca_sequencer_if;
  import rpsc_pkg::*;

  logic                start_req;
  logic                stop_req;
  logic                ack_clr;
  logic [STATUS_W-1:0] status;
  logic                g1_not_ok;
  logic                fan_act;
  logic                ca_ps_act;
  logic                i_ca_high;
  logic                u_ca_low;

  logic                fan_on_cmd;
  logic                ca_on_perm;
  logic                ca_delay_done;
  logic                ca_ok;
  logic                alarm;
  logic [3:0]          fault_code;
  logic [1:0]          retry_cnt;
  logic [3:0]          state;

  modport master (
    output start_req, stop_req, ack_clr, status, g1_not_ok,
           fan_act, ca_ps_act, i_ca_high, u_ca_low,
    input  fan_on_cmd, ca_on_perm, ca_delay_done, ca_ok, alarm,
           fault_code, retry_cnt, state
  );

  modport slave (
    input  start_req, stop_req, ack_clr, status, g1_not_ok,
           fan_act, ca_ps_act, i_ca_high, u_ca_low,
    output fan_on_cmd, ca_on_perm, ca_delay_done, ca_ok, alarm,
           fault_code, retry_cnt, state
  );

endinterface

// File: rtl/rpsc_cycle_timer.sv
// rpsc_cycle_timer
// Clear/enable up-counter with a terminal compare against a runtime limit.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   clr   : synchronous clear (wins over en)
//   en    : count enable
//   limit : terminal value; done is high while count == limit
//   done  : terminal-compare output
module rpsc_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Counter restarts from zero whenever the owner changes phase.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/rpsc_ca_sequencer.sv
// rpsc_ca_sequencer
// Start-up and protection sequencer for the RPSC cathode-anode supply:
// fan spin-up, supply permit, settle, hold-off, run monitoring, trip with
// bounded auto-retry, and lockout.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   bus   : rpsc_ca_sequencer_if.slave (status inputs, registered command
//           outputs, latched fault code, retry count, state diagnostics)
module rpsc_ca_sequencer
  import rpsc_pkg::*;
#(
  parameter int FAN_TMO_CYC = 400,
  parameter int PS_TMO_CYC  = 200,
  parameter int SETTLE_CYC  = 4,
  parameter int DELAY_CYC   = 16,
  parameter int COOL_CYC    = 100,
  parameter int RETRY_MAX   = 2
) (
  input logic               clk,
  input logic               reset,
  rpsc_ca_sequencer_if.slave bus
);

  localparam int MAX_CYC = max_int(max_int(max_int(FAN_TMO_CYC, PS_TMO_CYC),
                                           max_int(SETTLE_CYC, DELAY_CYC)),
                                   COOL_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;

  state_t          state_q, next_state;
  fault_t          fault_q, fault_d, trip_code, mon_code;
  logic [1:0]      retry_q, retry_d;
  logic            live_fault;
  logic            fan_q, perm_q, run_q, alarm_q;
  logic            fan_d, perm_d, run_d, alarm_d;
  logic            tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0]   tmr_limit;

  rpsc_cycle_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // Fault monitor: later assignments override earlier ones, so the
  // lowest-numbered active fault ends up in mon_code. Which faults are
  // armed depends on how far the start-up sequence has progressed.
  always_comb begin
    live_fault = (|bus.status) || bus.g1_not_ok;
    mon_code   = FLT_NONE;
    if (state_q inside {CA_DELAY, RUN}) begin
      if (bus.u_ca_low)  mon_code = FLT_U_CA_LOW;
      if (bus.i_ca_high) mon_code = FLT_I_CA_HIGH;
    end
    if ((state_q inside {CA_SETTLE, CA_DELAY, RUN}) && !bus.ca_ps_act) begin
      mon_code = FLT_PS_LOST;
    end
    if (bus.g1_not_ok) mon_code = FLT_G1_NOT_OK;
    if (|bus.status)   mon_code = status_fault(bus.status);
  end

  // Next-state logic. In each active state the order is fault, then stop,
  // then feedback/timer advance. Timer limits are N-1 so that a timed
  // state lasts exactly N cycles.
  always_comb begin
    next_state = state_q;
    trip_code  = FLT_NONE;
    tmr_en     = 1'b0;
    tmr_limit  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_req && !live_fault) next_state = FAN_START;
      end
      FAN_START: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(FAN_TMO_CYC - 1);
        if (mon_code != FLT_NONE) begin
          next_state = TRIP;
          trip_code  = mon_code;
        end else if (bus.stop_req) begin
          next_state = SHUTDOWN;
        end else if (bus.fan_act) begin
          next_state = CA_PERM;
        end else if (tmr_done) begin
          next_state = TRIP;
          trip_code  = FLT_FAN_TMO;
        end
      end
      CA_PERM: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(PS_TMO_CYC - 1);
        if (mon_code != FLT_NONE) begin
          next_state = TRIP;
          trip_code  = mon_code;
        end else if (bus.stop_req) begin
          next_state = SHUTDOWN;
        end else if (bus.ca_ps_act) begin
          next_state = CA_SETTLE;
        end else if (tmr_done) begin
          next_state = TRIP;
          trip_code  = FLT_PS_TMO;
        end
      end
      CA_SETTLE: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(SETTLE_CYC - 1);
        if (mon_code != FLT_NONE) begin
          next_state = TRIP;
          trip_code  = mon_code;
        end else if (bus.stop_req) begin
          next_state = SHUTDOWN;
        end else if (tmr_done) begin
          next_state = CA_DELAY;
        end
      end
      CA_DELAY: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(DELAY_CYC - 1);
        if (mon_code != FLT_NONE) begin
          next_state = TRIP;
          trip_code  = mon_code;
        end else if (bus.stop_req) begin
          next_state = SHUTDOWN;
        end else if (tmr_done) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (mon_code != FLT_NONE) begin
          next_state = TRIP;
          trip_code  = mon_code;
        end else if (bus.stop_req) begin
          next_state = SHUTDOWN;
        end
      end
      SHUTDOWN: begin
        tmr_en    = 1'b1;
        tmr_limit = TW'(COOL_CYC - 1);
        if (tmr_done) next_state = IDLE;
      end
      TRIP: begin
        // retry_q already includes the increment taken on TRIP entry.
        tmr_en    = 1'b1;
        tmr_limit = TW'(COOL_CYC - 1);
        if (tmr_done) begin
          if ((32'(retry_q) < RETRY_MAX) && !live_fault) next_state = FAN_START;
          else                                          next_state = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (bus.ack_clr && !live_fault) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bookkeeping and Moore output decode from the upcoming state, so the
  // registered outputs change on the same edge as the state register.
  always_comb begin
    fault_d = fault_q;
    retry_d = retry_q;
    if ((next_state == TRIP) && (state_q != TRIP)) begin
      if (retry_q != 2'b11)       retry_d = retry_q + 2'd1;
      if (fault_q == FLT_NONE)    fault_d = trip_code;
    end else if ((state_q == LOCKOUT) && (next_state == IDLE)) begin
      fault_d = FLT_NONE;
      retry_d = '0;
    end else if ((state_q == SHUTDOWN) && (next_state == IDLE)) begin
      retry_d = '0;
    end

    fan_d   = next_state inside {FAN_START, CA_PERM, CA_SETTLE, CA_DELAY,
                                 RUN, SHUTDOWN, TRIP};
    perm_d  = next_state inside {CA_PERM, CA_SETTLE, CA_DELAY, RUN};
    run_d   = (next_state == RUN);
    alarm_d = live_fault || (fault_d != FLT_NONE) || (next_state == LOCKOUT);
    tmr_clr = (next_state != state_q);
  end

  // State and output registers. Reset drops all commands immediately
  // (no cooling run-on) while alarm keeps tracking the live inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      fault_q <= FLT_NONE;
      retry_q <= '0;
      fan_q   <= 1'b0;
      perm_q  <= 1'b0;
      run_q   <= 1'b0;
      alarm_q <= live_fault;
    end else begin
      state_q <= next_state;
      fault_q <= fault_d;
      retry_q <= retry_d;
      fan_q   <= fan_d;
      perm_q  <= perm_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.fan_on_cmd    = fan_q;
  assign bus.ca_on_perm    = perm_q;
  assign bus.ca_delay_done = run_q;
  assign bus.ca_ok         = run_q;
  assign bus.alarm         = alarm_q;
  assign bus.fault_code    = fault_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_rpsc_ca_sequencer.sv
// tb_rpsc_ca_sequencer
// Directed bench for rpsc_ca_sequencer with short timing parameters
// (fan/ps timeout 8, settle 4, delay 16, cool 6, retry max 2).
module tb_rpsc_ca_sequencer;
  import rpsc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  rpsc_ca_sequencer_if bus ();

  rpsc_ca_sequencer #(
    .FAN_TMO_CYC (8),
    .PS_TMO_CYC  (8),
    .SETTLE_CYC  (4),
    .DELAY_CYC   (16),
    .COOL_CYC    (6),
    .RETRY_MAX   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Samples land 1 ns after the rising edge; inputs also change there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic check_state(input string tag, input state_t expected);
    check_output(tag, 32'(bus.state), 32'(expected));
  endtask

  task automatic check_cmds(input string tag, input logic fan, input logic perm,
                            input logic ok);
    check_output({tag, ".fan_on_cmd"}, 32'(bus.fan_on_cmd), 32'(fan));
    check_output({tag, ".ca_on_perm"}, 32'(bus.ca_on_perm), 32'(perm));
    check_output({tag, ".ca_ok"},      32'(bus.ca_ok),      32'(ok));
  endtask

  // From IDLE with fan and supply feedback already present: FAN_START,
  // CA_PERM, CA_SETTLE, then 4 settle cycles land in CA_DELAY.
  task automatic apply_stimulus_to_delay();
    bus.start_req = 1'b1;
    bus.fan_act   = 1'b1;
    bus.ca_ps_act = 1'b1;
    tick();
    bus.start_req = 1'b0;
    tick();
    tick();
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.start_req = 1'b0;
    bus.stop_req  = 1'b0;
    bus.ack_clr   = 1'b0;
    bus.status    = '0;
    bus.g1_not_ok = 1'b0;
    bus.fan_act   = 1'b0;
    bus.ca_ps_act = 1'b0;
    bus.i_ca_high = 1'b0;
    bus.u_ca_low  = 1'b0;

    $display("[TB] reset state");
    tick();
    tick();
    check_state("rst.state", IDLE);
    check_cmds("rst", 1'b0, 1'b0, 1'b0);
    check_output("rst.delay_done", 32'(bus.ca_delay_done), 0);
    check_output("rst.alarm",      32'(bus.alarm), 0);
    check_output("rst.fault_code", 32'(bus.fault_code), 0);
    check_output("rst.retry_cnt",  32'(bus.retry_cnt), 0);
    reset = 1'b1;
    tick();
    check_state("idle.hold", IDLE);

    $display("[TB] happy path");
    bus.start_req = 1'b1;
    tick();
    check_state("hp.fan_start", FAN_START);
    check_cmds("hp.fan_start", 1'b1, 1'b0, 1'b0);
    bus.start_req = 1'b0;
    tick();
    tick();
    bus.fan_act = 1'b1;
    tick();
    check_state("hp.ca_perm", CA_PERM);
    check_cmds("hp.ca_perm", 1'b1, 1'b1, 1'b0);
    tick();
    bus.ca_ps_act = 1'b1;
    tick();
    check_state("hp.settle", CA_SETTLE);
    repeat (3) tick();
    check_state("hp.settle_last", CA_SETTLE);
    tick();
    check_state("hp.delay_first", CA_DELAY);
    repeat (15) tick();
    check_state("hp.delay_last", CA_DELAY);
    check_output("hp.ok_before_run", 32'(bus.ca_ok), 0);
    tick();
    check_state("hp.run", RUN);
    check_cmds("hp.run", 1'b1, 1'b1, 1'b1);
    check_output("hp.delay_done", 32'(bus.ca_delay_done), 1);
    check_output("hp.fault_code", 32'(bus.fault_code), 0);
    check_output("hp.alarm",      32'(bus.alarm), 0);

    $display("[TB] stop from run");
    bus.stop_req = 1'b1;
    tick();
    check_state("stop.shutdown", SHUTDOWN);
    check_cmds("stop.shutdown", 1'b1, 1'b0, 1'b0);
    bus.stop_req  = 1'b0;
    bus.fan_act   = 1'b0;
    bus.ca_ps_act = 1'b0;
    repeat (5) tick();
    check_state("stop.cool_last", SHUTDOWN);
    check_output("stop.fan_last", 32'(bus.fan_on_cmd), 1);
    tick();
    check_state("stop.idle", IDLE);
    check_output("stop.fan_off", 32'(bus.fan_on_cmd), 0);

    $display("[TB] fan timeout");
    bus.start_req = 1'b1;
    tick();
    bus.start_req = 1'b0;
    repeat (7) tick();
    check_state("fan.last_wait", FAN_START);
    tick();
    check_state("fan.trip", TRIP);
    check_output("fan.code",  32'(bus.fault_code), 9);
    check_output("fan.retry", 32'(bus.retry_cnt), 1);
    check_cmds("fan.trip", 1'b1, 1'b0, 1'b0);
    check_output("fan.alarm", 32'(bus.alarm), 1);
    repeat (5) tick();
    check_state("fan.cool_last", TRIP);
    tick();
    check_state("fan.restart", FAN_START);
    check_output("fan.code_kept", 32'(bus.fault_code), 9);
    repeat (8) tick();
    check_state("fan.trip2", TRIP);
    check_output("fan.retry2", 32'(bus.retry_cnt), 2);
    repeat (6) tick();
    check_state("fan.lockout", LOCKOUT);
    check_cmds("fan.lockout", 1'b0, 1'b0, 1'b0);
    bus.ack_clr = 1'b1;
    tick();
    bus.ack_clr = 1'b0;
    check_state("fan.ack_idle", IDLE);
    check_output("fan.ack_code",  32'(bus.fault_code), 0);
    check_output("fan.ack_retry", 32'(bus.retry_cnt), 0);

    $display("[TB] repeated water_anode fault");
    apply_stimulus_to_delay();
    repeat (16) tick();
    check_state("rep.run1", RUN);
    bus.status[SB_WATER_ANODE] = 1'b1;
    tick();
    check_state("rep.trip1", TRIP);
    check_output("rep.code1",  32'(bus.fault_code), 3);
    check_output("rep.retry1", 32'(bus.retry_cnt), 1);
    bus.status = '0;
    repeat (6) tick();
    check_state("rep.restart", FAN_START);
    repeat (22) tick();
    check_state("rep.run2", RUN);
    check_output("rep.alarm_latched", 32'(bus.alarm), 1);
    bus.status[SB_WATER_ANODE] = 1'b1;
    tick();
    check_state("rep.trip2", TRIP);
    check_output("rep.retry2", 32'(bus.retry_cnt), 2);
    repeat (6) tick();
    check_state("rep.lockout", LOCKOUT);
    check_output("rep.code2", 32'(bus.fault_code), 3);
    bus.ack_clr = 1'b1;
    tick();
    bus.ack_clr = 1'b0;
    check_state("rep.ack_live_fault", LOCKOUT);
    bus.status = '0;
    tick();
    check_output("rep.lock_alarm", 32'(bus.alarm), 1);
    bus.ack_clr = 1'b1;
    tick();
    bus.ack_clr = 1'b0;
    check_state("rep.ack_idle", IDLE);
    check_output("rep.clr_code",  32'(bus.fault_code), 0);
    check_output("rep.clr_retry", 32'(bus.retry_cnt), 0);
    check_output("rep.clr_alarm", 32'(bus.alarm), 0);

    $display("[TB] simultaneous faults with stop in CA_DELAY");
    apply_stimulus_to_delay();
    check_state("sim.delay", CA_DELAY);
    bus.status[SB_CARD_POS] = 1'b1;
    bus.g1_not_ok = 1'b1;
    bus.stop_req  = 1'b1;
    tick();
    check_state("sim.trip", TRIP);
    check_output("sim.code", 32'(bus.fault_code), 1);
    bus.status    = '0;
    bus.g1_not_ok = 1'b0;
    bus.stop_req  = 1'b0;
    repeat (6) tick();
    check_state("sim.restart", FAN_START);
    bus.stop_req = 1'b1;
    tick();
    check_state("sim.stop_fan_start", SHUTDOWN);
    bus.stop_req = 1'b0;
    repeat (6) tick();
    check_state("sim.idle", IDLE);
    check_output("sim.retry_clr",  32'(bus.retry_cnt), 0);
    check_output("sim.code_kept",  32'(bus.fault_code), 1);

    $display("[TB] reset during CA_SETTLE");
    bus.start_req = 1'b1;
    tick();
    bus.start_req = 1'b0;
    tick();
    tick();
    tick();
    check_state("rs.settle", CA_SETTLE);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_state("rs.state", IDLE);
    check_cmds("rs", 1'b0, 1'b0, 1'b0);
    check_output("rs.code",  32'(bus.fault_code), 0);
    check_output("rs.alarm", 32'(bus.alarm), 0);

    $display("[TB] start blocked by status fault");
    bus.status[SB_WATER_GRID] = 1'b1;
    bus.start_req = 1'b1;
    tick();
    check_state("blk.idle", IDLE);
    check_output("blk.alarm", 32'(bus.alarm), 1);
    bus.status    = '0;
    bus.start_req = 1'b0;
    tick();

    $display("[TB] overcurrent and undervoltage together");
    apply_stimulus_to_delay();
    bus.i_ca_high = 1'b1;
    bus.u_ca_low  = 1'b1;
    tick();
    check_state("ca.trip", TRIP);
    check_output("ca.code", 32'(bus.fault_code), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
